// File: rtl/lut_cfg_loader_if.sv
// Bit-serial configuration bus between a bitstream source (master) and the
// LUT configuration loader (slave).
interface lut_cfg_loader_if #(
    parameter int CFG_WIDTH = 33,
    parameter int NUM_WORDS = 4,
    parameter int IDX_W     = 2
);
    logic                 start;
    logic                 bit_in;
    logic                 bit_valid;
    logic                 bit_ready;
    logic [CFG_WIDTH-1:0] config_out;
    logic [NUM_WORDS-1:0] cen_out;
    logic [IDX_W-1:0]     word_idx;
    logic                 done;
    logic                 err;

    modport master (
        output start, bit_in, bit_valid,
        input  bit_ready, config_out, cen_out, word_idx, done, err
    );

    modport slave (
        input  start, bit_in, bit_valid,
        output bit_ready, config_out, cen_out, word_idx, done, err
    );
endinterface

// File: rtl/lut_cfg_loader.sv
// Serial configuration loader for fracturable LUT slices.
// Deserializes MSB-first words {use_fracture, first_lut, second_lut}, presents
// each on config_out and strobes one slice's cen per committed word.
// Optional feature macro: LUT_CFG_PARITY_EN (one even-parity bit per word,
// bad words are dropped and flagged on a sticky err).
module lut_cfg_loader #(
    parameter int INPUTS    = 4,
    parameter int MEM_SIZE  = 2**INPUTS,
    parameter int CFG_WIDTH = 2*MEM_SIZE+1,
    parameter int NUM_WORDS = 4,
    parameter int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic           cclk,
    input  logic           rst_n,
    lut_cfg_loader_if.slave bus
);
    localparam int CNT_W = (CFG_WIDTH > 1) ? $clog2(CFG_WIDTH) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SHIFT  = 3'd1;
`ifdef LUT_CFG_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd2;
`endif
    localparam logic [2:0] ST_COMMIT = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]           state;
    logic [CFG_WIDTH-1:0] sr;
    logic [CFG_WIDTH-1:0] cfg_q;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic                 take;

`ifdef LUT_CFG_PARITY_EN
    logic err_q;
    assign bus.bit_ready = (state == ST_SHIFT) || (state == ST_PARITY);
    assign bus.err       = err_q;
`else
    assign bus.bit_ready = (state == ST_SHIFT);
    assign bus.err       = 1'b0;
`endif

    assign take           = bus.bit_valid && bus.bit_ready;
    assign bus.config_out = cfg_q;
    assign bus.word_idx   = idx;
    assign bus.done       = (state == ST_DONE);

    // One-hot slice strobe, live only during the COMMIT cycle.
    always_comb begin
        bus.cen_out = '0;
        for (int k = 0; k < NUM_WORDS; k++)
            bus.cen_out[k] = (state == ST_COMMIT) && (idx == IDX_W'(k));
    end

    // Load sequencer: shift, (parity check), commit, advance word index.
    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sr    <= '0;
            cfg_q <= '0;
            cnt   <= '0;
            idx   <= '0;
`ifdef LUT_CFG_PARITY_EN
            err_q <= 1'b0;
`endif
        end else if (bus.start) begin
            // Restart wins over any same-cycle bit; config_out is kept.
            state <= ST_SHIFT;
            cnt   <= '0;
            idx   <= '0;
`ifdef LUT_CFG_PARITY_EN
            err_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_SHIFT: if (take) begin
                    sr <= {sr[CFG_WIDTH-2:0], bus.bit_in};
                    if (cnt == CNT_W'(CFG_WIDTH-1)) begin
                        cnt <= '0;
`ifdef LUT_CFG_PARITY_EN
                        state <= ST_PARITY;
`else
                        state <= ST_COMMIT;
                        cfg_q <= {sr[CFG_WIDTH-2:0], bus.bit_in};
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef LUT_CFG_PARITY_EN
                ST_PARITY: if (take) begin
                    if ((^{sr, bus.bit_in}) == 1'b0) begin
                        state <= ST_COMMIT;
                        cfg_q <= sr;
                    end else begin
                        // Drop the word; the source resends it at the same index.
                        state <= ST_SHIFT;
                        err_q <= 1'b1;
                    end
                end
`endif
                ST_COMMIT: begin
                    if (idx < IDX_W'(NUM_WORDS-1)) begin
                        idx   <= idx + 1'b1;
                        state <= ST_SHIFT;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lut_cfg_loader.sv
// Self-checking bench for lut_cfg_loader: directed and randomized word
// streams checked against a list-of-commits reference model.
module tb_lut_cfg_loader;
    localparam int CW = 33;
    localparam int NW = 4;
    localparam int IW = 2;
`ifdef LUT_CFG_PARITY_EN
    localparam int WORD_CYC = CW + 2;
`else
    localparam int WORD_CYC = CW + 1;
`endif

    typedef struct {
        logic [NW-1:0] cen;
        logic [CW-1:0] cfg;
    } obs_t;

    logic cclk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    obs_t obs_q[$];
    obs_t exp_q[$];

    lut_cfg_loader_if #(.CFG_WIDTH(CW), .NUM_WORDS(NW), .IDX_W(IW)) bus ();

    lut_cfg_loader #(.INPUTS(4), .NUM_WORDS(NW)) dut (
        .cclk (cclk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 cclk = ~cclk;
    always @(posedge cclk) cyc <= cyc + 1;

    // Capture every strobe with the word presented alongside it.
    always @(negedge cclk)
        if (bus.cen_out != '0) obs_q.push_back('{bus.cen_out, bus.config_out});

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge cclk);
        bus.start = 1'b0;
    endtask

    // Present one bit after a random idle gap; returns once it has been taken.
    task automatic send_bit(input logic b, input int max_gap);
        int   gap;
        logic acc;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        bus.bit_valid = 1'b0;
        repeat (gap) @(negedge cclk);
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 100 && !acc; t++) begin
            acc = bus.bit_ready;
            @(negedge cclk);
        end
        bus.bit_valid = 1'b0;
        if (!acc) chk("bit_accept_timeout", acc, 1);
    endtask

    task automatic send_data(input logic [CW-1:0] w, input int max_gap);
        for (int i = CW - 1; i >= 0; i--) send_bit(w[i], max_gap);
    endtask

    task automatic send_word(input logic [CW-1:0] w, input int max_gap);
        send_data(w, max_gap);
`ifdef LUT_CFG_PARITY_EN
        send_bit(^w, max_gap);
`endif
    endtask

    task automatic wait_done();
        for (int t = 0; t < 500 && !bus.done; t++) @(negedge cclk);
    endtask

    task automatic check_commits(input string tag);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_cen%0d", tag, i), obs_q[i].cen, exp_q[i].cen);
            chk($sformatf("%s_cfg%0d", tag, i), obs_q[i].cfg, exp_q[i].cfg);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    function automatic logic [CW-1:0] rand_word();
        return CW'({$urandom(), $urandom()});
    endfunction

    initial begin
        logic [CW-1:0] w;
        logic [CW-1:0] held;
        logic          rdy_seen;
        int            c0;

        bus.start = 1'b0;
        bus.bit_in = 1'b0;
        bus.bit_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge cclk);
        chk("rst_ready", bus.bit_ready, 0);
        chk("rst_cfg", bus.config_out, 0);
        chk("rst_cen", bus.cen_out, 0);
        chk("rst_idx", bus.word_idx, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        rst_n = 1'b1;
        @(negedge cclk);
        chk("idle_ready", bus.bit_ready, 0);

        // Directed back-to-back load with bit_valid held high
        pulse_start();
        c0 = cyc;
        for (int k = 0; k < NW; k++) begin
            w = 33'h1_0000_0000 | CW'(k);
            exp_q.push_back('{NW'(1) << k, w});
            send_word(w, 0);
        end
        wait_done();
        chk("dir_cycles", cyc - c0, NW * WORD_CYC);
        chk("dir_done", bus.done, 1);
        @(negedge cclk);
        check_commits("dir");

        // Random words with random handshake gaps
        pulse_start();
        chk("rnd_done_clr", bus.done, 0);
        for (int k = 0; k < NW; k++) begin
            w = rand_word();
            exp_q.push_back('{NW'(1) << k, w});
            send_word(w, 3);
        end
        wait_done();
        chk("rnd_done", bus.done, 1);
        @(negedge cclk);
        check_commits("rnd");

        // Bits offered in DONE are ignored
        held = bus.config_out;
        rdy_seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            bus.bit_valid = 1'b1;
            bus.bit_in = $urandom_range(1, 0) == 1;
            rdy_seen |= bus.bit_ready;
            @(negedge cclk);
        end
        bus.bit_valid = 1'b0;
        chk("done_ready", rdy_seen, 0);
        chk("done_pulses", obs_q.size(), 0);
        chk("done_cfg_held", bus.config_out, held);
        chk("done_still", bus.done, 1);
        obs_q.delete();

        // Asynchronous reset in the middle of word 2
        pulse_start();
        for (int k = 0; k < 2; k++) begin
            w = rand_word();
            exp_q.push_back('{NW'(1) << k, w});
            send_word(w, 2);
        end
        w = rand_word();
        for (int i = CW - 1; i >= CW - 10; i--) send_bit(w[i], 1);
        @(negedge cclk);
        check_commits("pre_rst");
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_cfg", bus.config_out, 0);
        chk("mid_rst_idx", bus.word_idx, 0);
        chk("mid_rst_ready", bus.bit_ready, 0);
        chk("mid_rst_cen", bus.cen_out, 0);
        chk("mid_rst_done", bus.done, 0);
        @(negedge cclk);
        rst_n = 1'b1;
        @(negedge cclk);
        pulse_start();
        w = rand_word();
        exp_q.push_back('{NW'(1), w});
        send_word(w, 2);
        repeat (2) @(negedge cclk);
        check_commits("post_rst");
        chk("post_rst_idx", bus.word_idx, 1);

        // start colliding with a valid bit in word 1
        pulse_start();
        w = rand_word();
        exp_q.push_back('{NW'(1), w});
        send_word(w, 1);
        for (int i = 0; i < 5; i++) send_bit($urandom_range(1, 0) == 1, 1);
        bus.bit_valid = 1'b1;
        bus.bit_in = 1'b1;
        bus.start = 1'b1;
        @(negedge cclk);
        bus.start = 1'b0;
        bus.bit_valid = 1'b0;
        chk("coll_idx", bus.word_idx, 0);
        w = rand_word();
        exp_q.push_back('{NW'(1), w});
        send_word(w, 1);
        repeat (2) @(negedge cclk);
        check_commits("coll");

`ifdef LUT_CFG_PARITY_EN
        // Bad parity drops the word; resend at the same index
        pulse_start();
        w = rand_word();
        send_data(w, 1);
        send_bit(~(^w), 0);
        repeat (2) @(negedge cclk);
        chk("par_bad_pulses", obs_q.size(), 0);
        chk("par_bad_err", bus.err, 1);
        chk("par_bad_idx", bus.word_idx, 0);
        exp_q.push_back('{NW'(1), w});
        send_word(w, 1);
        repeat (2) @(negedge cclk);
        check_commits("par_resend");
        chk("par_err_sticky", bus.err, 1);
        pulse_start();
        chk("par_err_clr", bus.err, 0);
`else
        chk("err_tied", bus.err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lut_cfg_loader.md
# lut_cfg_loader

Serial configuration loader that sits directly upstream of the fracturable LUT slices in the configuration clock domain. It accepts a bitstream one bit at a time over a valid/ready handshake and deserializes it MSB-first into `CFG_WIDTH`-bit words, where each word is `{use_fracture, first_lut, second_lut}`. For each completed word it presents the word on `config_out` and pulses exactly one LUT's `cen` for one cycle. Words load in order until `NUM_WORDS` LUTs are configured, then the block reports `done`.

## Interface
- `INPUTS`, default 4: LUT input count per half.
- `MEM_SIZE`, default `2**INPUTS`: bits per LUT half.
- `CFG_WIDTH`, default `2*MEM_SIZE+1`: word width, 33 by default.
- `NUM_WORDS`, default 4: number of LUT slices fed; must be ≥1.
- `IDX_W`, default `$clog2(NUM_WORDS)`, minimum 1: width of `word_idx`.
- `cclk`  in  1  configuration clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin or restart a load.
- `bit_in`  in  1  serial config bit.
- `bit_valid`  in  1  `bit_in` is valid.
- `bit_ready`  out  1  loader accepts a bit this cycle; a function of registered state only.
- `config_out`  out  CFG_WIDTH  last committed word; drives every slice's `config_in`.
- `cen_out`  out  NUM_WORDS  one-hot, one-cycle load strobe; bit k drives slice k `cen`.
- `word_idx`  out  IDX_W  index of the word currently being shifted.
- `done`  out  1  all words committed.
- `err`  out  1  sticky parity error; 0 unless the macro is defined.

## Operation
- States:
  - IDLE: reset state.
  - SHIFT: accepting data bits.
  - PARITY: accepting the parity bit; exists only with the macro.
  - COMMIT: one-cycle word strobe.
  - DONE: load complete.
- Bit transfer: a bit is accepted when `bit_valid && bit_ready`. `bit_ready` = 1 in SHIFT and PARITY only.
- Shift register: `sr <= {sr[CFG_WIDTH-2:0], bit_in}`. The first bit received becomes `config_out[CFG_WIDTH-1]`, the `use_fracture` bit.
- Bit counter: counts 0..CFG_WIDTH-1 and clears on each word boundary.
- Transitions:
  - IDLE→SHIFT on `start`.
  - SHIFT→COMMIT when bit CFG_WIDTH-1 is accepted (→PARITY with the macro).
  - COMMIT→SHIFT while `word_idx < NUM_WORDS-1`; `word_idx` increments on that edge.
  - COMMIT→DONE after the last word.
  - DONE→SHIFT on `start`.
- COMMIT cycle: `config_out <= sr` is registered on entry. `cen_out[word_idx]` = 1 for exactly that cycle, otherwise all zeros. `config_out` holds its value until the next commit.
- `start` in any state:
  - Returns to SHIFT with bit counter = 0 and `word_idx` = 0.
  - Clears `done` and `err`; `config_out` is untouched.
  - Has priority over a same-cycle bit handshake; that bit is discarded.
  - `start` in COMMIT still emits that cycle's `cen_out` pulse.
- DONE: `done` = 1 and `bit_ready` = 0. Incoming bits are ignored until `start`.
- Reset, including mid-word: IDLE, `sr` = 0, `config_out` = 0, `cen_out` = 0, `word_idx` = 0, `done` = 0, `err` = 0, `bit_ready` = 0. Partially shifted bits are lost.
- Stalls: `bit_valid` low during SHIFT holds all state; there is no timeout.

## Timing
- The last data bit (or parity bit) is accepted on edge N. COMMIT occupies cycle N→N+1, when `cen_out` is high. `bit_ready` returns at N+1.
- Per-word overhead: 1 dead cycle, so the minimum word period is CFG_WIDTH+1 cycles (CFG_WIDTH+2 with parity).
- `done` rises on the edge following the last COMMIT cycle.
- Consumer LUTs sample `config_in` on the same `cclk` edge that ends the `cen` pulse. `config_out` is stable for that whole cycle.

## Configuration
- `LUT_CFG_PARITY_EN` defined:
  - Each word is followed by one parity bit, with even parity over the CFG_WIDTH data bits plus the parity bit.
  - On mismatch: no COMMIT and no `cen_out` pulse; `err` <= 1 (sticky); `word_idx` unchanged; go to SHIFT so the word can be resent.
  - On match: normal COMMIT.
- Undefined: no PARITY state, `err` tied to 0, words are back-to-back data bits.

## Test plan
- Reset then `start`, stream 4×33 bits with word k = 33'h1_0000_0000 | k, `bit_valid` held high → 4 single-cycle `cen_out` pulses 4'b0001, 4'b0010, 4'b0100, 4'b1000, each with matching `config_out`; `done` = 1 after the 4th; total 4×34 cycles from the first bit.
- Random `bit_valid` gaps, including during the bit CFG_WIDTH-1 handshake → identical `config_out` values; no `cen_out` pulse before bit 33 of a word is accepted.
- `rst_n` asserted mid-word 2 after 10 bits → all outputs are reset values immediately (asynchronously); after `start`, word 0 reloads cleanly.
- `start` coincident with a valid bit mid-word 1 → that bit is dropped, `word_idx` = 0, and the next 33 bits form word 0.
- With `LUT_CFG_PARITY_EN`, send word 0 with a bad parity bit → no `cen_out`, `err` = 1, `word_idx` = 0; resend with correct parity → `cen_out` = 4'b0001 and `err` stays 1.
- In DONE, drive 50 bits → `bit_ready` = 0, no `cen_out` pulses, `config_out` unchanged.
